// File: rtl/editor_buf_ctrl.sv
// Text-editor character buffer controller: turns accepted keystrokes into buffer
// writes and cursor moves, and sweeps the whole buffer with spaces on a clear request.
module editor_buf_ctrl #(
    parameter int COLS       = 80,
    parameter int ROWS       = 24,
    parameter int BLINK_BITS = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  key_valid,
    input  logic [7:0]            key_code,
    output logic                  key_ready,
    input  logic                  clr_req,
    input  logic                  caps_on,
    input  logic [2:0]            color_selector,
    output logic                  wr_en,
    output logic [11:0]           wr_addr,
    output logic [9:0]            wr_data,
    output logic [6:0]            cursor_col,
    output logic [4:0]            cursor_row,
    output logic                  cursor_blink,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    state_t                state;
    logic                  pending;
    logic [7:0]            key_reg;
    logic [6:0]            col, clr_col;
    logic [4:0]            row, clr_row;
    logic [BLINK_BITS-1:0] blink_cnt;

    logic       is_print, is_bs, is_cr, bs_ok, is_lower;
    logic [6:0] next_col, prev_col, wr_char;
    logic [4:0] next_row, prev_row;

    always_comb begin
        is_print = (key_reg >= 8'h20) && (key_reg <= 8'h7E);
        is_bs    = (key_reg == 8'h08);
        is_cr    = (key_reg == 8'h0D);
        is_lower = (key_reg >= 8'h61) && (key_reg <= 8'h7A);
        bs_ok    = is_bs && !((col == '0) && (row == '0));
        next_col = (col == LAST_COL) ? '0 : col + 7'd1;
        next_row = (col != LAST_COL) ? row : ((row == LAST_ROW) ? '0 : row + 5'd1);
        prev_col = (col == '0) ? LAST_COL : col - 7'd1;
        prev_row = (col == '0) ? row - 5'd1 : row;
    end

    // Backspace writes at the cell it moves to, not at the current cursor.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = {row, col};
        wr_char = key_reg[6:0];
        case (state)
            WRITE: begin
                if (is_print) begin
                    wr_en   = 1'b1;
                    wr_char = (caps_on && is_lower) ? key_reg[6:0] - 7'h20 : key_reg[6:0];
                end else if (bs_ok) begin
                    wr_en   = 1'b1;
                    wr_addr = {prev_row, prev_col};
                    wr_char = 7'h20;
                end
            end
            CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = {clr_row, clr_col};
                wr_char = 7'h20;
            end
            default: ;
        endcase
        wr_data = {color_selector, wr_char};
    end

    assign key_ready    = (state == IDLE) && !pending && !clr_req;
    assign busy         = (state != IDLE) || pending;
    assign cursor_col   = col;
    assign cursor_row   = row;
    assign cursor_blink = blink_cnt[BLINK_BITS-1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            pending   <= 1'b0;
            key_reg   <= '0;
            col       <= '0;
            row       <= '0;
            clr_col   <= '0;
            clr_row   <= '0;
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + {{(BLINK_BITS-1){1'b0}}, 1'b1};
            case (state)
                IDLE: begin
                    if (pending || clr_req) begin
                        state   <= CLEAR;
                        pending <= 1'b1;
                        clr_col <= '0;
                        clr_row <= '0;
                    end else if (key_valid) begin
                        key_reg <= key_code;
                        state   <= WRITE;
                    end
                end
                WRITE: begin
                    pending <= pending | clr_req;
                    state   <= IDLE;
                    if (is_print) begin
                        col <= next_col;
                        row <= next_row;
                    end else if (bs_ok) begin
                        col <= prev_col;
                        row <= prev_row;
                    end else if (is_cr) begin
                        col <= '0;
                        row <= (row == LAST_ROW) ? '0 : row + 5'd1;
                    end
                end
                CLEAR: begin
                    // Requests arriving mid-sweep are covered by this sweep.
                    if ((clr_col == LAST_COL) && (clr_row == LAST_ROW)) begin
                        state   <= IDLE;
                        pending <= 1'b0;
                        col     <= '0;
                        row     <= '0;
                    end else if (clr_col == LAST_COL) begin
                        clr_col <= '0;
                        clr_row <= clr_row + 5'd1;
                    end else begin
                        clr_col <= clr_col + 7'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_editor_buf_ctrl.sv
// Directed bench for editor_buf_ctrl: keystroke writes, cursor wrap, backspace,
// enter, buffer clear, reset abort and blink counter.
module tb_editor_buf_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        key_valid;
    logic [7:0]  key_code;
    logic        key_ready;
    logic        clr_req;
    logic        caps_on;
    logic [2:0]  color_selector;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [9:0]  wr_data;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        cursor_blink;
    logic        busy;

    int n_checks = 0;
    int n_fails  = 0;

    int          wr_count  = 0;
    int          non_space = 0;
    logic [11:0] last_addr = '0;

    editor_buf_ctrl #(.COLS(80), .ROWS(24), .BLINK_BITS(4)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .key_ready(key_ready), .clr_req(clr_req), .caps_on(caps_on),
        .color_selector(color_selector), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .cursor_blink(cursor_blink), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) begin
            wr_count++;
            if (wr_data[6:0] != 7'h20) non_space++;
            last_addr = wr_addr;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; key_valid = 1'b0; clr_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic send_key(input logic [7:0] code, output logic we,
                            output logic [11:0] a, output logic [9:0] d);
        key_valid = 1'b1; key_code = code;
        check("key_ready_before_accept", int'(key_ready), 1);
        @(posedge clk); #1;
        key_valid = 1'b0;
        we = wr_en; a = wr_addr; d = wr_data;
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input string tag);
        int cyc = 0;
        while (busy && cyc < 5000) begin
            @(posedge clk); #1; cyc++;
        end
        check(tag, int'(busy), 0);
    endtask

    logic        we;
    logic [11:0] a;
    logic [9:0]  d;
    int          base, base_ns, snap, cyc;

    initial begin
        key_code = '0; caps_on = 1'b0; color_selector = 3'b000;
        do_reset();

        check("rst_wr_en", int'(wr_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_key_ready", int'(key_ready), 1);
        check("rst_col", int'(cursor_col), 0);
        check("rst_row", int'(cursor_row), 0);
        check("rst_blink", int'(cursor_blink), 0);
        repeat (8) @(posedge clk);
        #1 check("blink_high", int'(cursor_blink), 1);
        repeat (8) @(posedge clk);
        #1 check("blink_wrap", int'(cursor_blink), 0);

        // 'a' with caps lock -> 'A'
        caps_on = 1'b1; color_selector = 3'b100;
        send_key(8'h61, we, a, d);
        check("caps_we", int'(we), 1);
        check("caps_addr", int'(a), 'h000);
        check("caps_data", int'(d), 'h241);
        check("caps_col", int'(cursor_col), 1);
        check("caps_row", int'(cursor_row), 0);

        // walk to end of row 0, then wrap and backspace across the row edge
        caps_on = 1'b0; color_selector = 3'b010;
        for (int i = 0; i < 78; i++) send_key(8'h62, we, a, d);
        check("walk_col", int'(cursor_col), 79);
        send_key(8'h78, we, a, d);
        check("eol_we", int'(we), 1);
        check("eol_addr", int'(a), 'h04F);
        check("eol_data", int'(d), 'h178);
        check("eol_col", int'(cursor_col), 0);
        check("eol_row", int'(cursor_row), 1);
        send_key(8'h08, we, a, d);
        check("bs_we", int'(we), 1);
        check("bs_addr", int'(a), 'h04F);
        check("bs_data", int'(d), 'h120);
        check("bs_col", int'(cursor_col), 79);
        check("bs_row", int'(cursor_row), 0);

        // unsupported code is swallowed
        send_key(8'h07, we, a, d);
        check("bel_we", int'(we), 0);
        check("bel_col", int'(cursor_col), 79);

        // backspace at origin, lowercase without caps, '{' untouched by caps
        do_reset();
        send_key(8'h08, we, a, d);
        check("bs0_we", int'(we), 0);
        check("bs0_col", int'(cursor_col), 0);
        check("bs0_row", int'(cursor_row), 0);
        color_selector = 3'b001;
        send_key(8'h61, we, a, d);
        check("nocaps_data", int'(d), 'h0E1);
        caps_on = 1'b1;
        send_key(8'h7B, we, a, d);
        check("brace_data", int'(d), 'h0FB);
        caps_on = 1'b0;

        // last-cell wrap and enter wrap
        do_reset();
        send_key(8'h0D, we, a, d);
        check("cr_we", int'(we), 0);
        check("cr_row", int'(cursor_row), 1);
        for (int i = 0; i < 22; i++) send_key(8'h0D, we, a, d);
        for (int i = 0; i < 79; i++) send_key(8'h63, we, a, d);
        check("pos_row", int'(cursor_row), 23);
        check("pos_col", int'(cursor_col), 79);
        color_selector = 3'b111;
        send_key(8'h7A, we, a, d);
        check("last_addr", int'(a), 'hBCF);
        check("last_data", int'(d), 'h3FA);
        check("last_col", int'(cursor_col), 0);
        check("last_row", int'(cursor_row), 0);
        for (int i = 0; i < 23; i++) send_key(8'h0D, we, a, d);
        send_key(8'h0D, we, a, d);
        check("crwrap_we", int'(we), 0);
        check("crwrap_row", int'(cursor_row), 0);
        check("crwrap_col", int'(cursor_col), 0);

        // clear beats a simultaneous key
        send_key(8'h41, we, a, d);
        base = wr_count; base_ns = non_space;
        key_valid = 1'b1; key_code = 8'h42; clr_req = 1'b1;
        #1 check("clr_key_ready", int'(key_ready), 0);
        @(posedge clk); #1;
        key_valid = 1'b0; clr_req = 1'b0;
        check("clr_busy", int'(busy), 1);
        wait_idle("clr_done");
        check("clr_count", wr_count - base, 1920);
        check("clr_chars", non_space - base_ns, 0);
        check("clr_last_addr", int'(last_addr), 'hBCF);
        check("clr_col", int'(cursor_col), 0);
        check("clr_row", int'(cursor_row), 0);
        send_key(8'h51, we, a, d);
        check("post_clr_we", int'(we), 1);
        check("post_clr_addr", int'(a), 'h000);

        // second request mid-clear is absorbed
        base = wr_count;
        clr_req = 1'b1; @(posedge clk); #1; clr_req = 1'b0;
        repeat (100) @(posedge clk);
        #1 clr_req = 1'b1; @(posedge clk); #1; clr_req = 1'b0;
        wait_idle("absorb_done");
        repeat (20) @(posedge clk);
        #1 check("absorb_count", wr_count - base, 1920);
        check("absorb_busy", int'(busy), 0);

        // reset aborts a clear
        do_reset();
        base = wr_count;
        clr_req = 1'b1; @(posedge clk); #1; clr_req = 1'b0;
        cyc = 0;
        while (wr_count - base < 100 && cyc < 3000) begin @(posedge clk); #1; cyc++; end
        clr_req = 1'b1; @(posedge clk); #1; clr_req = 1'b0;
        while (wr_count - base < 500 && cyc < 3000) begin @(posedge clk); #1; cyc++; end
        check("abort_reached", int'(wr_count - base >= 500), 1);
        reset = 1'b0; @(posedge clk); #1; reset = 1'b1;
        check("abort_wr_en", int'(wr_en), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_col", int'(cursor_col), 0);
        check("abort_row", int'(cursor_row), 0);
        snap = wr_count;
        repeat (50) @(posedge clk);
        #1 check("abort_no_writes", wr_count - snap, 0);
        check("abort_bound", int'(wr_count - base <= 1920), 1);

        // back-to-back keys held valid
        base = wr_count;
        key_valid = 1'b1; key_code = 8'h41;
        check("b2b_r0", int'(key_ready), 1);
        @(posedge clk); #1;
        check("b2b_r1", int'(key_ready), 0);
        check("b2b_w0_addr", int'(wr_addr), 'h000);
        check("b2b_w0_en", int'(wr_en), 1);
        key_code = 8'h07;
        @(posedge clk); #1;
        check("b2b_r2", int'(key_ready), 1);
        @(posedge clk); #1;
        check("b2b_r3", int'(key_ready), 0);
        check("b2b_bel_en", int'(wr_en), 0);
        key_code = 8'h42;
        @(posedge clk); #1;
        check("b2b_r4", int'(key_ready), 1);
        @(posedge clk); #1;
        key_valid = 1'b0;
        check("b2b_w1_addr", int'(wr_addr), 'h001);
        check("b2b_w1_en", int'(wr_en), 1);
        @(posedge clk); #1;
        check("b2b_count", wr_count - base, 2);
        check("b2b_col", int'(cursor_col), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/editor_buf_ctrl.md
EDITOR_BUF_CTRL -- requirements
Module: editor_buf_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 80, characters per editing line (2..127).
REQ-002 SHALL have parameter ROWS, default 24, editing lines (2..32).
REQ-003 SHALL have parameter BLINK_BITS, default 24, width of the cursor blink counter.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port key_valid  input  1  a keystroke is offered on key_code.
REQ-007 SHALL have port key_code  input  8  ASCII code of the offered keystroke.
REQ-008 SHALL have port key_ready  output  1  keystroke accepted when key_valid and key_ready are both high at a rising edge.
REQ-009 SHALL have port clr_req  input  1  single-cycle pulse requesting a full buffer clear.
REQ-010 SHALL have port caps_on  input  1  caps lock state.
REQ-011 SHALL have port color_selector  input  3  RGB colour stored with each written cell.
REQ-012 SHALL have port wr_en  output  1  character-buffer write strobe.
REQ-013 SHALL have port wr_addr  output  12  buffer address {row[4:0], col[6:0]}.
REQ-014 SHALL have port wr_data  output  10  {colour[2:0], char[6:0]}.
REQ-015 SHALL have port cursor_col  output  7  current cursor column.
REQ-016 SHALL have port cursor_row  output  5  current cursor row.
REQ-017 SHALL have port cursor_blink  output  1  cursor visibility phase, equal to blink counter MSB.
REQ-018 SHALL have port busy  output  1  high while not in IDLE or while a clear is pending.

Function
REQ-019 SHALL implement FSM states IDLE, WRITE, CLEAR.
REQ-020 key_ready SHALL be high only in IDLE with no clear pending and clr_req low.
REQ-021 clr_req SHALL set a pending flag in any state; in IDLE a pending/incoming clear SHALL move to CLEAR, and it takes priority over a simultaneous key.
REQ-022 On key acceptance the code SHALL be registered and the FSM SHALL enter WRITE; wr_en SHALL be high for exactly the next cycle only when the code requires a write.
REQ-023 Printable codes 0x20..0x7E SHALL write at the cursor; when caps_on=1, 0x61..0x7A SHALL be converted by subtracting 0x20.
REQ-024 After a printable write, the cursor SHALL advance one column; at col COLS-1 it SHALL go to col 0, next row; from (ROWS-1, COLS-1) it SHALL wrap to (0,0).
REQ-025 Backspace 0x08 SHALL move the cursor back one cell (col 0 -> col COLS-1 of the previous row) and write 0x20 at the new position; at (0,0) it SHALL do nothing.
REQ-026 Enter 0x0D SHALL move to col 0 of the next row with no write; from row ROWS-1 it SHALL go to row 0.
REQ-027 All other codes SHALL be accepted and discarded with no write and no cursor change.
REQ-028 Cursor registers SHALL update at the end of the WRITE cycle; WRITE SHALL last one cycle and then return to IDLE, so at most one key is accepted every 2 cycles.
REQ-029 CLEAR SHALL write 0x20 with the current color_selector to every cell, row-major from (0,0) to (ROWS-1, COLS-1), one cell per cycle with wr_en high, for ROWS*COLS cycles.
REQ-030 On the cycle after the last clear write the FSM SHALL return to IDLE, with the cursor at (0,0) and the pending flag cleared.
REQ-031 A clr_req arriving during CLEAR SHALL be absorbed into the current clear and SHALL NOT cause a second clear.
REQ-032 wr_data colour SHALL be sampled from color_selector in the cycle the write occurs.
REQ-033 The blink counter SHALL free-run and wrap modulo 2^BLINK_BITS.

Reset
REQ-034 With reset low at a rising edge, the FSM SHALL go to IDLE; cursor, blink counter and pending flag SHALL go to 0; wr_en and busy SHALL be 0, and key_ready SHALL be 1 on the first cycle after release.
REQ-035 A reset during WRITE or CLEAR SHALL abort the operation with no further wr_en pulses.

Verification
REQ-036 Reset, offer 'a' (0x61) with caps_on=1 and color 3'b100 -> one wr_en, addr 0x000, data {100, 0x41}; cursor becomes (0,1).
REQ-037 Cursor at (0,COLS-1), offer 'x' -> write at col 79; cursor (1,0); then 0x08 -> write 0x20 at {0,79}; cursor (0,79).
REQ-038 Cursor at (23,79), offer 'z' -> cursor (0,0); then 0x0D from row 23 -> row 0, no wr_en.
REQ-039 clr_req and key_valid high together in IDLE -> key not accepted; exactly 1920 wr_en cycles with char 0x20; cursor (0,0); busy falls; key then accepted.
REQ-040 Second clr_req mid-CLEAR, then reset asserted at write 500 -> 1920 writes are not exceeded; after reset, wr_en=0 and cursor (0,0).
REQ-041 Back-to-back key_valid with codes 0x41, 0x07, 0x42 -> key_ready pattern 1,0,1,0,1; writes at cols 0 and 1 only.
